// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: position, walk/jump/gravity and facing for one fighter.
// All motion registers update once per frame on a one-cycle strobe derived
// from the scan counters during vertical blanking.
module player_motion_ctrl #(
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 512,
  parameter int unsigned X_START    = 64,
  parameter int unsigned GROUND_Y   = 266,
  parameter int unsigned WALK_SPEED = 4,
  parameter int unsigned JUMP_V     = 14,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned TICK_LINE  = 481
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [1:0] move_state,
  output logic       facing_right,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RISE = 2'd2,
    FALL = 2'd3
  } state_t;

  localparam logic [9:0]         X_MIN_V   = 10'(X_MIN);
  localparam logic [9:0]         X_MAX_V   = 10'(X_MAX);
  localparam logic [9:0]         X_START_V = 10'(X_START);
  localparam logic [9:0]         GROUND_V  = 10'(GROUND_Y);
  localparam logic [9:0]         STEP_V    = 10'(WALK_SPEED);
  localparam logic [9:0]         TICK_V    = 10'(TICK_LINE);
  localparam logic [9:0]         Y_LAUNCH  = 10'(GROUND_Y - JUMP_V);
  localparam logic [10:0]        X_LO_LIM  = 11'(X_MIN + WALK_SPEED);
  localparam logic [10:0]        X_HI_LIM  = 11'(X_MAX - WALK_SPEED);
  localparam logic signed [10:0] GROUND_S  = 11'(GROUND_Y);
  localparam logic signed [6:0]  GRAV7     = 7'(GRAVITY);
  localparam logic signed [7:0]  GRAV8     = 8'(GRAVITY);
  localparam logic signed [7:0]  VY_CAP    = 8'sd63;
  // The launch frame is itself the first rise step: the sprite moves up by
  // JUMP_V and gravity is already applied to the velocity on that tick.
  localparam logic signed [6:0]  VY_LAUNCH = 7'(GRAVITY) - 7'(JUMP_V);

  state_t             state, state_nxt;
  logic [9:0]         x_q, x_nxt;
  logic [9:0]         y_q, y_nxt;
  logic signed [6:0]  vy, vy_nxt;
  logic               facing_q, facing_nxt;
  logic               match_q, match_d, tick_q;
  logic               jump_q, jump_pending;
  logic               go_left, go_right, walking;
  logic signed [10:0] y_sum;
  logic signed [6:0]  vy_rise;
  logic signed [7:0]  vy_fall;

  // Frame strobe from the held scan position, plus jump press latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q      <= 1'b0;
      match_d      <= 1'b0;
      tick_q       <= 1'b0;
      jump_q       <= 1'b0;
      jump_pending <= 1'b0;
    end else begin
      match_q <= (hCount == '0) && (vCount == TICK_V);
      match_d <= match_q;
      tick_q  <= match_q & ~match_d;
      jump_q  <= btn_jump;
      if (tick_q)
        jump_pending <= 1'b0;
      else if (btn_jump && !jump_q)
        jump_pending <= 1'b1;
    end
  end

  // State register: motion registers advance only on the frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x_q      <= X_START_V;
      y_q      <= GROUND_V;
      vy       <= '0;
      facing_q <= 1'b1;
    end else if (tick_q) begin
      state    <= state_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      vy       <= vy_nxt;
      facing_q <= facing_nxt;
    end
  end

  // Next-state: horizontal walk with saturation, vertical jump/gravity FSM.
  always_comb begin
    go_left    = btn_left & ~btn_right;
    go_right   = btn_right & ~btn_left;
    walking    = go_left | go_right;
    y_sum      = $signed({1'b0, y_q}) + 11'(vy);
    vy_rise    = vy + GRAV7;
    vy_fall    = $signed({vy[6], vy}) + GRAV8;
    state_nxt  = state;
    x_nxt      = x_q;
    y_nxt      = y_q;
    vy_nxt     = vy;
    facing_nxt = facing_q;

    if (go_left) begin
      x_nxt      = ({1'b0, x_q} < X_LO_LIM) ? X_MIN_V : x_q - STEP_V;
      facing_nxt = 1'b0;
    end else if (go_right) begin
      x_nxt      = ({1'b0, x_q} > X_HI_LIM) ? X_MAX_V : x_q + STEP_V;
      facing_nxt = 1'b1;
    end

    case (state)
      IDLE, WALK: begin
        if (jump_pending) begin
          y_nxt     = Y_LAUNCH;
          vy_nxt    = VY_LAUNCH;
          state_nxt = VY_LAUNCH[6] ? RISE : FALL;
        end else begin
          y_nxt     = GROUND_V;
          vy_nxt    = '0;
          state_nxt = walking ? WALK : IDLE;
        end
      end
      RISE: begin
        if (y_sum[10]) begin
          y_nxt     = '0;
          vy_nxt    = '0;
          state_nxt = FALL;
        end else begin
          y_nxt     = y_sum[9:0];
          vy_nxt    = vy_rise;
          state_nxt = vy_rise[6] ? RISE : FALL;
        end
      end
      FALL: begin
        if (y_sum >= GROUND_S) begin
          y_nxt     = GROUND_V;
          vy_nxt    = '0;
          state_nxt = walking ? WALK : IDLE;
        end else begin
          y_nxt  = y_sum[9:0];
          vy_nxt = (vy_fall > VY_CAP) ? 7'sd63 : vy_fall[6:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs straight from registers.
  always_comb begin
    player_x     = x_q;
    player_y     = y_q;
    move_state   = state;
    facing_right = facing_q;
    frame_tick   = tick_q;
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl using a compressed scan pattern
// that still holds each scan position for 4 clk cycles.
module tb_player_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hCount, vCount;
  logic       btn_left, btn_right, btn_jump;
  logic [9:0] player_x, player_y;
  logic [1:0] move_state;
  logic       facing_right, frame_tick;
  logic [9:0] x2, y2;
  logic [1:0] ms2;
  logic       f2, t2;

  int checks = 0;
  int errors = 0;
  int ticks;

  typedef struct {
    logic       l, r, j;
    logic [9:0] x, y;
    logic [1:0] st;
    logic       f;
  } vec_t;

  vec_t        vecs[7];
  logic [9:0]  ytab[29];
  logic [1:0]  sttab[29];

  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .player_x(player_x), .player_y(player_y), .move_state(move_state),
    .facing_right(facing_right), .frame_tick(frame_tick)
  );

  player_motion_ctrl #(.X_START(6)) dut2 (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .player_x(x2), .player_y(y2), .move_state(ms2),
    .facing_right(f2), .frame_tick(t2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic [9:0] h, input logic [9:0] v);
    hCount = h;
    vCount = v;
    repeat (4) begin
      @(negedge clk);
      if (frame_tick) ticks++;
    end
  endtask

  task automatic pulse_jump();
    btn_jump = 1'b1;
    repeat (2) @(negedge clk);
    btn_jump = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame();
    ticks = 0;
    hold(10'd5, 10'd480);
    hold(10'd0, 10'd481);
    hold(10'd1, 10'd481);
    hold(10'd0, 10'd482);
    hold(10'd7, 10'd482);
    chk("tick_count", ticks, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 10'd64, 10'd266, 2'd0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 10'd68, 10'd266, 2'd1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 10'd72, 10'd266, 2'd1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 10'd68, 10'd266, 2'd1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 10'd68, 10'd266, 2'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 10'd68, 10'd266, 2'd0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 10'd68, 10'd252, 2'd2, 1'b0};

    ytab = '{10'd252, 10'd239, 10'd227, 10'd216, 10'd206, 10'd197, 10'd189,
             10'd182, 10'd176, 10'd171, 10'd167, 10'd164, 10'd162, 10'd161,
             10'd161, 10'd162, 10'd164, 10'd167, 10'd171, 10'd176, 10'd182,
             10'd189, 10'd197, 10'd206, 10'd216, 10'd227, 10'd239, 10'd252,
             10'd266};
    for (int i = 0; i < 29; i++)
      sttab[i] = (i < 13) ? 2'd2 : ((i < 28) ? 2'd3 : 2'd0);

    rst = 1'b1;
    hCount = 10'd0; vCount = 10'd0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    #1;
    chk("rst_x", player_x, 64);
    chk("rst_y", player_y, 266);
    chk("rst_state", move_state, 0);
    chk("rst_facing", facing_right, 1);
    chk("rst_tick", frame_tick, 0);
    chk("rst_x2", x2, 6);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Idle frames after reset.
    for (int k = 0; k < 3; k++) begin
      frame();
      chk("idle_x", player_x, 64);
      chk("idle_y", player_y, 266);
      chk("idle_state", move_state, 0);
      chk("idle_facing", facing_right, 1);
    end

    // Table-driven single-frame vectors.
    for (int i = 0; i < 7; i++) begin
      btn_left = vecs[i].l;
      btn_right = vecs[i].r;
      if (vecs[i].j) pulse_jump();
      frame();
      chk("vec_x", player_x, vecs[i].x);
      chk("vec_y", player_y, vecs[i].y);
      chk("vec_state", move_state, vecs[i].st);
      chk("vec_facing", facing_right, vecs[i].f);
    end

    // Rest of the jump with the button held through landing.
    btn_jump = 1'b1;
    for (int i = 1; i < 29; i++) begin
      frame();
      chk("traj_y", player_y, ytab[i]);
      chk("traj_state", move_state, sttab[i]);
    end
    for (int k = 0; k < 2; k++) begin
      frame();
      chk("held_jump_y", player_y, 266);
      chk("held_jump_state", move_state, 0);
    end
    btn_jump = 1'b0;
    @(negedge clk);

    // Jump while walking right, extra presses in the air.
    btn_right = 1'b1;
    pulse_jump();
    for (int i = 0; i < 29; i++) begin
      if (i == 3 || i == 10) pulse_jump();
      frame();
      chk("air_x", player_x, 72 + 4 * i);
      chk("air_y", player_y, ytab[i]);
      chk("air_state", move_state, (i == 28) ? 2'd1 : sttab[i]);
      chk("air_facing", facing_right, 1);
    end

    // Right saturation from the start position.
    do_reset();
    for (int k = 1; k <= 120; k++) begin
      frame();
      chk("sat_right_x", player_x, (64 + 4 * k > 512) ? 512 : 64 + 4 * k);
      chk("sat_right_state", move_state, 1);
    end
    btn_right = 1'b0;
    frame();
    chk("release_x", player_x, 512);
    chk("release_state", move_state, 0);

    // Left saturation at X_MIN from x = 6.
    do_reset();
    chk("left_start_x2", x2, 6);
    btn_left = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      frame();
      chk("left_x2", x2, (k == 1) ? 2 : 0);
      chk("left_facing2", f2, 0);
      chk("left_x", player_x, 64 - 4 * k);
    end
    btn_left = 1'b0;

    // Asynchronous reset during the fall.
    pulse_jump();
    for (int i = 0; i <= 22; i++) frame();
    chk("pre_rst_y", player_y, 197);
    chk("pre_rst_state", move_state, 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_x", player_x, 64);
    chk("async_rst_y", player_y, 266);
    chk("async_rst_state", move_state, 0);
    chk("async_rst_facing", facing_right, 1);
    chk("async_rst_tick", frame_tick, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame();
    chk("post_rst_y", player_y, 266);
    chk("post_rst_state", move_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
